raizing_extratext_ram: RTL and testbench
========================================

# raizing_extratext_ram

CPU-side owner of the extra-text layer memories: the text VRAM, line-select RAM and line-scroll RAM that the extra-text renderer reads every scanline. It decodes 68000-style bus cycles into byte-masked writes and readbacks, with DTACK handshaking. It also serves the renderer's three read ports with a fixed two-cycle latency. It sits between the main CPU bus decoder and the extra-text renderer, in the video clock domain.

## Interface
Parameters:
- VRAM_AW, 12, text VRAM word-address width (4096 words)
- LINE_AW, 8, select/scroll RAM word-address width (256 words each)

Ports:
- CLK  in  1  video clock (96 MHz domain); the only clock
- RESET_N  in  1  reset, asynchronous and active-low
- CPU_CS  in  1  window select from CPU address decoder, already in CLK domain
- CPU_ADDR  in  13  word offset within window (byte address bits 13:1)
- CPU_RW  in  1  1 = read, 0 = write
- CPU_UDS_N / CPU_LDS_N  in  1 each  upper/lower data strobes
- CPU_DIN  in  16  write data
- CPU_DOUT  out  16  read data; valid while CPU_DTACK_N = 0
- CPU_DTACK_N  out  1  acknowledge, active-low
- TEXTVRAM_ADDR  in  12 / TEXTVRAM_DATA  out  16  renderer tile-map port
- TEXTSELECT_ADDR  in  8 / TEXTSELECT_DATA  out  16  renderer line-select port
- TEXTSCROLL_ADDR  in  8 / TEXTSCROLL_DATA  out  16  renderer line-scroll port

## Operation
- Memory map, in CPU_ADDR words: 0x0000–0x0FFF VRAM; 0x1000–0x10FF select RAM; 0x1800–0x18FF scroll RAM; everything else is unmapped.
- Unmapped accesses: writes are dropped, reads return 0x0000, and DTACK is still given.
- Each memory is dual-ported. Port A is renderer read-only. Port B is CPU read/write with byte enables: UDS_N=0 writes bits 15:8, LDS_N=0 writes bits 7:0.
- A request is the rising edge of `strobe = CPU_CS & (~CPU_UDS_N | ~CPU_LDS_N)`. Only one cycle is accepted per strobe assertion.
- CPU FSM:
  - IDLE: on a request, latch addr/rw/din/strobes, then go to ACC.
  - ACC: drive port B. For a write, assert byte-enables for exactly one cycle, then go to ACK. For a read, go to RD.
  - RD: capture port-B data (one-cycle RAM latency) into CPU_DOUT, then go to ACK.
  - ACK: CPU_DTACK_N=0. Hold until strobe falls, then DTACK_N=1 and go to IDLE. CPU_DOUT is held until the next read.
- Renderer ports never stall and never see CPU arbitration. Address is registered at cycle 0, RAM output at cycle 1, output register at cycle 2.
- If the CPU writes and the renderer reads the same word in the same cycle, the renderer gets the old data (read-before-write). No hazard flag is raised.
- Reset mid-cycle: FSM goes to IDLE, CPU_DTACK_N=1, CPU_DOUT=0, and any pending write is discarded. RAM contents are not cleared.

## Timing
- Reset values: CPU_DTACK_N=1, CPU_DOUT=0x0000, TEXTVRAM_DATA / TEXTSELECT_DATA / TEXTSCROLL_DATA = 0x0000.
- Renderer latency: data for an address presented at edge N is valid after edge N+2. This matches the renderer's address-at-state-0, sample-at-state-2 sequence.
- CPU write: request edge at N, RAM written at N+1 (ACC), DTACK_N low after N+2.
- CPU read: request edge at N, DTACK_N low with valid CPU_DOUT after N+3.
- If strobe drops before ACK, the cycle still completes internally. DTACK_N goes low for one cycle, then IDLE. No retrigger occurs without a new rising edge.
- A back-to-back strobe (fall then rise) is accepted starting from the IDLE cycle that follows the fall.

## Structure
- Shared package `raizing_pkg` holds:
  - region base/limit constants TXT_VRAM_BASE=0x0000, TXT_SEL_BASE=0x1000, TXT_SCR_BASE=0x1800;
  - the CPU FSM state enum (IDLE, ACC, RD, ACK).
- Sub-module `raizing_dpram_be`: parameterised-width dual-port RAM with registered outputs, port-B byte enables and read-before-write. It is instantiated three times; the top holds the decoder, FSM and output muxing.

## Test plan
- Reset with RESET_N=0 mid-ACK -> DTACK_N=1, CPU_DOUT=0 and all renderer outputs 0 on the same cycle; the next request completes normally.
- Word write 0xA5C3 to VRAM word 0x123 (both strobes), then renderer reads 0x123 -> TEXTVRAM_DATA=0xA5C3 two edges after the address; DTACK_N low at N+2.
- Byte writes: write 0xFFFF to select word 0x10, then UDS-only 0x12xx -> CPU readback 0x12FF with DTACK_N low at N+3.
- Scroll RAM: write word 0x1805=0x0040 -> TEXTSCROLL_DATA at address 0x05 reads 0x0040; select word 0x05 is unchanged.
- Unmapped: write to 0x1400 then read 0x1400 -> CPU_DOUT=0x0000, DTACK still asserted, no memory modified.
- Same-cycle collision: renderer reads VRAM 0x200 (old 0x1111) during a CPU write of 0x2222 -> renderer gets 0x1111, then 0x2222 on the next read.

Source files
------------

// File: rtl/raizing_pkg.sv
// Shared definitions for the extra-text layer memories:
// CPU window region bounds, region decode and CPU bus FSM states.
package raizing_pkg;

    localparam logic [12:0] TXT_VRAM_BASE  = 13'h0000;
    localparam logic [12:0] TXT_VRAM_LIMIT = 13'h0FFF;
    localparam logic [12:0] TXT_SEL_BASE   = 13'h1000;
    localparam logic [12:0] TXT_SEL_LIMIT  = 13'h10FF;
    localparam logic [12:0] TXT_SCR_BASE   = 13'h1800;
    localparam logic [12:0] TXT_SCR_LIMIT  = 13'h18FF;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        RD,
        ACK
    } cpu_state_e;

    typedef enum logic [1:0] {
        RGN_NONE,
        RGN_VRAM,
        RGN_SEL,
        RGN_SCR
    } region_e;

    // VRAM starts at word 0, so only its upper bound needs testing.
    function automatic region_e decode_region(input logic [12:0] a);
        region_e r;
        r = RGN_NONE;
        if (a <= TXT_VRAM_LIMIT) begin
            r = RGN_VRAM;
        end else if (a >= TXT_SEL_BASE && a <= TXT_SEL_LIMIT) begin
            r = RGN_SEL;
        end else if (a >= TXT_SCR_BASE && a <= TXT_SCR_LIMIT) begin
            r = RGN_SCR;
        end
        return r;
    endfunction

endpackage

// File: rtl/raizing_dpram_be.sv
// Dual-port RAM: port A read-only, registered address/RAM/output
// (2-edge latency); port B byte-enabled write plus 1-cycle read.
// Ports: clk_i, rst_ni, a_addr_i/a_data_o, b_addr_i/b_be_i/b_din_i/b_dout_o.
module raizing_dpram_be
    import raizing_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [AW-1:0]   a_addr_i,
    output logic [DW-1:0]   a_data_o,
    input  logic [AW-1:0]   b_addr_i,
    input  logic [DW/8-1:0] b_be_i,
    input  logic [DW-1:0]   b_din_i,
    output logic [DW-1:0]   b_dout_o
);

    localparam int NB = DW / 8;

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] a_addr_q;
    logic [DW-1:0] a_raw_q;
    logic [DW-1:0] a_out_q;
    logic [DW-1:0] b_raw_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_addr_q <= '0;
            a_out_q  <= '0;
        end else begin
            a_addr_q <= a_addr_i;
            a_out_q  <= a_raw_q;
        end
    end

    // Reads sample the array before this edge's write lands,
    // giving read-before-write on both ports.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++) begin
            if (b_be_i[i]) begin
                mem_q[b_addr_i][i*8 +: 8] <= b_din_i[i*8 +: 8];
            end
        end
        a_raw_q <= mem_q[a_addr_q];
        b_raw_q <= mem_q[b_addr_i];
    end

    assign a_data_o = a_out_q;
    assign b_dout_o = b_raw_q;

endmodule

// File: rtl/raizing_extratext_ram.sv
// CPU-side owner of the extra-text VRAM, line-select and line-scroll RAMs.
// Ports: CLK/RESET_N, 68000-style CPU bus with DTACK, three renderer ports.
module raizing_extratext_ram
    import raizing_pkg::*;
#(
    parameter int VRAM_AW = 12,
    parameter int LINE_AW = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               CPU_CS,
    input  logic [12:0]        CPU_ADDR,
    input  logic               CPU_RW,
    input  logic               CPU_UDS_N,
    input  logic               CPU_LDS_N,
    input  logic [15:0]        CPU_DIN,
    output logic [15:0]        CPU_DOUT,
    output logic               CPU_DTACK_N,
    input  logic [VRAM_AW-1:0] TEXTVRAM_ADDR,
    output logic [15:0]        TEXTVRAM_DATA,
    input  logic [LINE_AW-1:0] TEXTSELECT_ADDR,
    output logic [15:0]        TEXTSELECT_DATA,
    input  logic [LINE_AW-1:0] TEXTSCROLL_ADDR,
    output logic [15:0]        TEXTSCROLL_DATA
);

    logic       strobe;
    cpu_state_e state_q, state_d;
    logic       strobe_q;
    logic [12:0] addr_q, addr_d;
    logic       rw_q, rw_d;
    logic [15:0] din_q, din_d;
    logic [1:0] be_q, be_d;
    logic [15:0] dout_q, dout_d;
    logic       dtack_n_q, dtack_n_d;
    region_e    rgn;
    logic       wr_acc;
    logic [1:0] be_vram, be_sel, be_scr;
    logic [15:0] vram_b, sel_b, scr_b;

    assign strobe = CPU_CS & (~CPU_UDS_N | ~CPU_LDS_N);
    assign rgn    = decode_region(addr_q);

    // Byte enables live only in ACC, so each write lasts one cycle.
    assign wr_acc  = (state_q == ACC) && !rw_q;
    assign be_vram = (wr_acc && rgn == RGN_VRAM) ? be_q : 2'b00;
    assign be_sel  = (wr_acc && rgn == RGN_SEL)  ? be_q : 2'b00;
    assign be_scr  = (wr_acc && rgn == RGN_SCR)  ? be_q : 2'b00;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            strobe_q  <= 1'b0;
            addr_q    <= '0;
            rw_q      <= 1'b1;
            din_q     <= '0;
            be_q      <= '0;
            dout_q    <= '0;
            dtack_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            strobe_q  <= strobe;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            din_q     <= din_d;
            be_q      <= be_d;
            dout_q    <= dout_d;
            dtack_n_q <= dtack_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        din_d     = din_q;
        be_d      = be_q;
        dout_d    = dout_q;
        dtack_n_d = dtack_n_q;
        unique case (state_q)
            IDLE: begin
                if (strobe && !strobe_q) begin
                    addr_d  = CPU_ADDR;
                    rw_d    = CPU_RW;
                    din_d   = CPU_DIN;
                    be_d    = {~CPU_UDS_N, ~CPU_LDS_N};
                    state_d = ACC;
                end
            end
            ACC: begin
                state_d = rw_q ? RD : ACK;
            end
            RD: begin
                unique case (rgn)
                    RGN_VRAM: dout_d = vram_b;
                    RGN_SEL:  dout_d = sel_b;
                    RGN_SCR:  dout_d = scr_b;
                    default:  dout_d = 16'h0000;
                endcase
                state_d = ACK;
            end
            ACK: begin
                // First ACK cycle always asserts DTACK so a strobe
                // that dropped early still sees one acknowledge.
                if (dtack_n_q) begin
                    dtack_n_d = 1'b0;
                end else if (!strobe) begin
                    dtack_n_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign CPU_DOUT    = dout_q;
    assign CPU_DTACK_N = dtack_n_q;

    raizing_dpram_be #(.AW(VRAM_AW), .DW(16)) u_vram (
        .clk_i    (CLK),
        .rst_ni   (RESET_N),
        .a_addr_i (TEXTVRAM_ADDR),
        .a_data_o (TEXTVRAM_DATA),
        .b_addr_i (addr_q[VRAM_AW-1:0]),
        .b_be_i   (be_vram),
        .b_din_i  (din_q),
        .b_dout_o (vram_b)
    );

    raizing_dpram_be #(.AW(LINE_AW), .DW(16)) u_sel (
        .clk_i    (CLK),
        .rst_ni   (RESET_N),
        .a_addr_i (TEXTSELECT_ADDR),
        .a_data_o (TEXTSELECT_DATA),
        .b_addr_i (addr_q[LINE_AW-1:0]),
        .b_be_i   (be_sel),
        .b_din_i  (din_q),
        .b_dout_o (sel_b)
    );

    raizing_dpram_be #(.AW(LINE_AW), .DW(16)) u_scr (
        .clk_i    (CLK),
        .rst_ni   (RESET_N),
        .a_addr_i (TEXTSCROLL_ADDR),
        .a_data_o (TEXTSCROLL_DATA),
        .b_addr_i (addr_q[LINE_AW-1:0]),
        .b_be_i   (be_scr),
        .b_din_i  (din_q),
        .b_dout_o (scr_b)
    );

endmodule

// File: tb/tb_raizing_extratext_ram.sv
// Self-checking bench for raizing_extratext_ram: directed bus scenarios
// plus randomized CPU and renderer traffic against a memory-map model.
module tb_raizing_extratext_ram;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        CPU_CS;
    logic [12:0] CPU_ADDR;
    logic        CPU_RW;
    logic        CPU_UDS_N;
    logic        CPU_LDS_N;
    logic [15:0] CPU_DIN;
    logic [15:0] CPU_DOUT;
    logic        CPU_DTACK_N;
    logic [11:0] TEXTVRAM_ADDR;
    logic [15:0] TEXTVRAM_DATA;
    logic [7:0]  TEXTSELECT_ADDR;
    logic [15:0] TEXTSELECT_DATA;
    logic [7:0]  TEXTSCROLL_ADDR;
    logic [15:0] TEXTSCROLL_DATA;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] m_vram [4096];
    logic [15:0] m_sel  [256];
    logic [15:0] m_scr  [256];
    logic [12:0] pv [8];
    logic [12:0] ps [8];
    logic [12:0] pc [8];

    always #5 clk = ~clk;

    raizing_extratext_ram dut (
        .CLK             (clk),
        .RESET_N         (RESET_N),
        .CPU_CS          (CPU_CS),
        .CPU_ADDR        (CPU_ADDR),
        .CPU_RW          (CPU_RW),
        .CPU_UDS_N       (CPU_UDS_N),
        .CPU_LDS_N       (CPU_LDS_N),
        .CPU_DIN         (CPU_DIN),
        .CPU_DOUT        (CPU_DOUT),
        .CPU_DTACK_N     (CPU_DTACK_N),
        .TEXTVRAM_ADDR   (TEXTVRAM_ADDR),
        .TEXTVRAM_DATA   (TEXTVRAM_DATA),
        .TEXTSELECT_ADDR (TEXTSELECT_ADDR),
        .TEXTSELECT_DATA (TEXTSELECT_DATA),
        .TEXTSCROLL_ADDR (TEXTSCROLL_ADDR),
        .TEXTSCROLL_DATA (TEXTSCROLL_DATA)
    );

    function automatic logic [15:0] model_read(input logic [12:0] a);
        if (a < 13'h1000) return m_vram[a[11:0]];
        if (a >= 13'h1000 && a < 13'h1100) return m_sel[a[7:0]];
        if (a >= 13'h1800 && a < 13'h1900) return m_scr[a[7:0]];
        return 16'h0000;
    endfunction

    function automatic void model_write(input logic [12:0] a,
                                        input logic [15:0] d,
                                        input logic uds_n,
                                        input logic lds_n);
        logic [15:0] w;
        w = model_read(a);
        if (!uds_n) w[15:8] = d[15:8];
        if (!lds_n) w[7:0] = d[7:0];
        if (a < 13'h1000) m_vram[a[11:0]] = w;
        else if (a >= 13'h1000 && a < 13'h1100) m_sel[a[7:0]] = w;
        else if (a >= 13'h1800 && a < 13'h1900) m_scr[a[7:0]] = w;
    endfunction

    // Called on a negedge; returns on a negedge with the strobe released.
    // lat = edges from request to DTACK low; negative on timeout.
    task automatic cpu_access(input logic rw, input logic [12:0] a,
                              input logic [15:0] d, input logic uds_n,
                              input logic lds_n, output logic [15:0] rdata,
                              output int lat);
        CPU_CS = 1'b1;
        CPU_ADDR = a;
        CPU_RW = rw;
        CPU_DIN = d;
        CPU_UDS_N = uds_n;
        CPU_LDS_N = lds_n;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (CPU_DTACK_N && lat < 20);
        if (CPU_DTACK_N) lat = -1;
        rdata = CPU_DOUT;
        CPU_CS = 1'b0;
        CPU_UDS_N = 1'b1;
        CPU_LDS_N = 1'b1;
        for (int k = 0; k < 20 && CPU_DTACK_N !== 1'b1; k++) @(negedge clk);
        if (CPU_DTACK_N !== 1'b1) lat = -2;
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        CPU_CS = 1'b0;
        CPU_ADDR = '0;
        CPU_RW = 1'b1;
        CPU_UDS_N = 1'b1;
        CPU_LDS_N = 1'b1;
        CPU_DIN = '0;
        TEXTVRAM_ADDR = '0;
        TEXTSELECT_ADDR = '0;
        TEXTSCROLL_ADDR = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (CPU_DTACK_N !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_dtack: got %b want 1", CPU_DTACK_N);
        end
        tests_run++;
        if (CPU_DOUT !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_dout: got %h want 0000", CPU_DOUT);
        end
        tests_run++;
        if ({TEXTVRAM_DATA, TEXTSELECT_DATA, TEXTSCROLL_DATA} !== 48'h0) begin
            tests_failed++;
            $display("FAIL rst_render: got %h %h %h want 0",
                     TEXTVRAM_DATA, TEXTSELECT_DATA, TEXTSCROLL_DATA);
        end
        RESET_N = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_write;
        logic [15:0] r;
        int lat;
        cpu_access(1'b0, 13'h124, 16'h0F0F, 1'b0, 1'b0, r, lat);
        model_write(13'h124, 16'h0F0F, 1'b0, 1'b0);
        TEXTVRAM_ADDR = 12'h124;
        cpu_access(1'b0, 13'h123, 16'hA5C3, 1'b0, 1'b0, r, lat);
        model_write(13'h123, 16'hA5C3, 1'b0, 1'b0);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL wr_dtack_lat: got %0d want 3", lat);
        end
        repeat (2) @(negedge clk);
        TEXTVRAM_ADDR = 12'h123;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (TEXTVRAM_DATA !== m_vram[12'h124]) begin
            tests_failed++;
            $display("FAIL vram_n1_old: got %h want %h",
                     TEXTVRAM_DATA, m_vram[12'h124]);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (TEXTVRAM_DATA !== 16'hA5C3) begin
            tests_failed++;
            $display("FAIL vram_n2: got %h want a5c3", TEXTVRAM_DATA);
        end
    endtask

    task automatic test_byte_writes;
        logic [15:0] r;
        int lat;
        cpu_access(1'b0, 13'h1010, 16'hFFFF, 1'b0, 1'b0, r, lat);
        model_write(13'h1010, 16'hFFFF, 1'b0, 1'b0);
        cpu_access(1'b0, 13'h1010, 16'h12AB, 1'b0, 1'b1, r, lat);
        model_write(13'h1010, 16'h12AB, 1'b0, 1'b1);
        cpu_access(1'b1, 13'h1010, 16'h0000, 1'b0, 1'b0, r, lat);
        tests_run++;
        if (r !== 16'h12FF) begin
            tests_failed++;
            $display("FAIL uds_only: got %h want 12ff", r);
        end
        tests_run++;
        if (lat !== 4) begin
            tests_failed++;
            $display("FAIL rd_dtack_lat: got %0d want 4", lat);
        end
        cpu_access(1'b0, 13'h1011, 16'h5566, 1'b0, 1'b0, r, lat);
        model_write(13'h1011, 16'h5566, 1'b0, 1'b0);
        cpu_access(1'b0, 13'h1011, 16'hCD34, 1'b1, 1'b0, r, lat);
        model_write(13'h1011, 16'hCD34, 1'b1, 1'b0);
        cpu_access(1'b1, 13'h1011, 16'h0000, 1'b1, 1'b0, r, lat);
        tests_run++;
        if (r !== 16'h5534) begin
            tests_failed++;
            $display("FAIL lds_only: got %h want 5534", r);
        end
    endtask

    task automatic test_scroll;
        logic [15:0] r;
        int lat;
        cpu_access(1'b0, 13'h1005, 16'hBEEF, 1'b0, 1'b0, r, lat);
        model_write(13'h1005, 16'hBEEF, 1'b0, 1'b0);
        cpu_access(1'b0, 13'h1805, 16'h0040, 1'b0, 1'b0, r, lat);
        model_write(13'h1805, 16'h0040, 1'b0, 1'b0);
        TEXTSCROLL_ADDR = 8'h05;
        TEXTSELECT_ADDR = 8'h05;
        repeat (3) @(negedge clk);
        tests_run++;
        if (TEXTSCROLL_DATA !== 16'h0040) begin
            tests_failed++;
            $display("FAIL scroll_render: got %h want 0040", TEXTSCROLL_DATA);
        end
        tests_run++;
        if (TEXTSELECT_DATA !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL select_kept: got %h want beef", TEXTSELECT_DATA);
        end
    endtask

    task automatic test_unmapped;
        logic [15:0] r;
        int lat;
        cpu_access(1'b0, 13'h0400, 16'h5A5A, 1'b0, 1'b0, r, lat);
        model_write(13'h0400, 16'h5A5A, 1'b0, 1'b0);
        cpu_access(1'b0, 13'h1000, 16'h6B6B, 1'b0, 1'b0, r, lat);
        model_write(13'h1000, 16'h6B6B, 1'b0, 1'b0);
        cpu_access(1'b0, 13'h1800, 16'h7C7C, 1'b0, 1'b0, r, lat);
        model_write(13'h1800, 16'h7C7C, 1'b0, 1'b0);
        cpu_access(1'b0, 13'h1400, 16'hDEAD, 1'b0, 1'b0, r, lat);
        model_write(13'h1400, 16'hDEAD, 1'b0, 1'b0);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL unmap_wr_dtack: got %0d want 3", lat);
        end
        cpu_access(1'b1, 13'h0400, 16'h0000, 1'b0, 1'b0, r, lat);
        cpu_access(1'b1, 13'h1400, 16'h0000, 1'b0, 1'b0, r, lat);
        tests_run++;
        if (r !== 16'h0000 || lat !== 4) begin
            tests_failed++;
            $display("FAIL unmap_rd: got %h lat %0d want 0000 lat 4", r, lat);
        end
        foreach (pv[i]) begin
            logic [12:0] a;
            a = (i == 0) ? 13'h0400 : (i == 1) ? 13'h1000 : 13'h1800;
            if (i < 3) begin
                cpu_access(1'b1, a, 16'h0000, 1'b0, 1'b0, r, lat);
                tests_run++;
                if (r !== model_read(a)) begin
                    tests_failed++;
                    $display("FAIL unmap_alias %h: got %h want %h",
                             a, r, model_read(a));
                end
            end
        end
    endtask

    task automatic test_collision;
        logic [15:0] r;
        int lat;
        cpu_access(1'b0, 13'h0200, 16'h1111, 1'b0, 1'b0, r, lat);
        model_write(13'h0200, 16'h1111, 1'b0, 1'b0);
        TEXTVRAM_ADDR = 12'h200;
        CPU_CS = 1'b1;
        CPU_ADDR = 13'h0200;
        CPU_RW = 1'b0;
        CPU_DIN = 16'h2222;
        CPU_UDS_N = 1'b0;
        CPU_LDS_N = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (TEXTVRAM_DATA !== 16'h1111) begin
            tests_failed++;
            $display("FAIL collide_old: got %h want 1111", TEXTVRAM_DATA);
        end
        tests_run++;
        if (CPU_DTACK_N !== 1'b0) begin
            tests_failed++;
            $display("FAIL collide_dtack: got %b want 0", CPU_DTACK_N);
        end
        CPU_CS = 1'b0;
        CPU_UDS_N = 1'b1;
        CPU_LDS_N = 1'b1;
        model_write(13'h0200, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (TEXTVRAM_DATA !== 16'h2222) begin
            tests_failed++;
            $display("FAIL collide_new: got %h want 2222", TEXTVRAM_DATA);
        end
    endtask

    task automatic test_early_drop;
        logic [15:0] r;
        int lat;
        int lows;
        int first;
        CPU_CS = 1'b1;
        CPU_ADDR = 13'h0300;
        CPU_RW = 1'b0;
        CPU_DIN = 16'h3333;
        CPU_UDS_N = 1'b0;
        CPU_LDS_N = 1'b0;
        @(posedge clk);
        @(negedge clk);
        CPU_CS = 1'b0;
        CPU_UDS_N = 1'b1;
        CPU_LDS_N = 1'b1;
        model_write(13'h0300, 16'h3333, 1'b0, 1'b0);
        lows = 0;
        first = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!CPU_DTACK_N) begin
                lows++;
                if (first < 0) first = k;
            end
        end
        tests_run++;
        if (lows !== 1 || first !== 1) begin
            tests_failed++;
            $display("FAIL early_drop: lows %0d at %0d want 1 at 1", lows, first);
        end
        cpu_access(1'b1, 13'h0300, 16'h0000, 1'b0, 1'b0, r, lat);
        tests_run++;
        if (r !== 16'h3333) begin
            tests_failed++;
            $display("FAIL early_drop_data: got %h want 3333", r);
        end
    endtask

    task automatic test_hold_ack;
        int lows;
        int highs;
        CPU_CS = 1'b1;
        CPU_ADDR = 13'h0301;
        CPU_RW = 1'b0;
        CPU_DIN = 16'h4444;
        CPU_UDS_N = 1'b0;
        CPU_LDS_N = 1'b0;
        model_write(13'h0301, 16'h4444, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        lows = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!CPU_DTACK_N) lows++;
        end
        tests_run++;
        if (lows !== 5) begin
            tests_failed++;
            $display("FAIL hold_ack: low %0d of 5 cycles", lows);
        end
        CPU_CS = 1'b0;
        CPU_UDS_N = 1'b1;
        CPU_LDS_N = 1'b1;
        highs = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (CPU_DTACK_N) highs++;
        end
        tests_run++;
        if (highs !== 4) begin
            tests_failed++;
            $display("FAIL release_ack: high %0d of 4 cycles", highs);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] r;
        logic [15:0] d;
        int lat;
        for (int i = 0; i < 4; i++) begin
            d = 16'($urandom);
            cpu_access(1'b0, 13'h0500 + 13'(i), d, 1'b0, 1'b0, r, lat);
            model_write(13'h0500 + 13'(i), d, 1'b0, 1'b0);
            tests_run++;
            if (lat !== 3) begin
                tests_failed++;
                $display("FAIL b2b_wr%0d: lat %0d want 3", i, lat);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cpu_access(1'b1, 13'h0500 + 13'(i), 16'h0, 1'b0, 1'b0, r, lat);
            tests_run++;
            if (r !== m_vram[12'h500 + 12'(i)] || lat !== 4) begin
                tests_failed++;
                $display("FAIL b2b_rd%0d: got %h lat %0d want %h lat 4",
                         i, r, lat, m_vram[12'h500 + 12'(i)]);
            end
        end
    endtask

    task automatic test_reset_mid_ack;
        logic [15:0] r;
        int lat;
        TEXTVRAM_ADDR = 12'h123;
        TEXTSELECT_ADDR = 8'h10;
        TEXTSCROLL_ADDR = 8'h05;
        CPU_CS = 1'b1;
        CPU_ADDR = 13'h0123;
        CPU_RW = 1'b1;
        CPU_UDS_N = 1'b0;
        CPU_LDS_N = 1'b0;
        for (int k = 0; k < 20 && CPU_DTACK_N; k++) @(negedge clk);
        tests_run++;
        if (CPU_DTACK_N !== 1'b0 || CPU_DOUT !== m_vram[12'h123]) begin
            tests_failed++;
            $display("FAIL pre_rst_rd: dtack %b dout %h want 0 %h",
                     CPU_DTACK_N, CPU_DOUT, m_vram[12'h123]);
        end
        #1 RESET_N = 1'b0;
        #1;
        tests_run++;
        if (CPU_DTACK_N !== 1'b1 || CPU_DOUT !== 16'h0000) begin
            tests_failed++;
            $display("FAIL mid_rst_cpu: dtack %b dout %h want 1 0000",
                     CPU_DTACK_N, CPU_DOUT);
        end
        tests_run++;
        if ({TEXTVRAM_DATA, TEXTSELECT_DATA, TEXTSCROLL_DATA} !== 48'h0) begin
            tests_failed++;
            $display("FAIL mid_rst_render: got %h %h %h want 0",
                     TEXTVRAM_DATA, TEXTSELECT_DATA, TEXTSCROLL_DATA);
        end
        CPU_CS = 1'b0;
        CPU_UDS_N = 1'b1;
        CPU_LDS_N = 1'b1;
        @(negedge clk);
        RESET_N = 1'b1;
        @(negedge clk);
        cpu_access(1'b1, 13'h1010, 16'h0, 1'b0, 1'b0, r, lat);
        tests_run++;
        if (r !== m_sel[8'h10] || lat !== 4) begin
            tests_failed++;
            $display("FAIL post_rst_rd: got %h lat %0d want %h lat 4",
                     r, lat, m_sel[8'h10]);
        end
        tests_run++;
        if (TEXTSCROLL_DATA !== m_scr[8'h05]) begin
            tests_failed++;
            $display("FAIL post_rst_render: got %h want %h",
                     TEXTSCROLL_DATA, m_scr[8'h05]);
        end
    endtask

    task automatic test_random_cpu;
        logic [15:0] r;
        logic [15:0] d;
        logic [12:0] a;
        logic [1:0] st;
        logic rw;
        int lat;
        int sel;
        for (int i = 0; i < 8; i++) begin
            pv[i] = 13'($urandom_range(0, 4095));
            ps[i] = 13'h1000 | 13'($urandom_range(0, 255));
            pc[i] = 13'h1800 | 13'($urandom_range(0, 255));
            d = 16'($urandom);
            cpu_access(1'b0, pv[i], d, 1'b0, 1'b0, r, lat);
            model_write(pv[i], d, 1'b0, 1'b0);
            d = 16'($urandom);
            cpu_access(1'b0, ps[i], d, 1'b0, 1'b0, r, lat);
            model_write(ps[i], d, 1'b0, 1'b0);
            d = 16'($urandom);
            cpu_access(1'b0, pc[i], d, 1'b0, 1'b0, r, lat);
            model_write(pc[i], d, 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            unique case (sel)
                0: a = pv[$urandom_range(0, 7)];
                1: a = ps[$urandom_range(0, 7)];
                2: a = pc[$urandom_range(0, 7)];
                default: a = ($urandom_range(0, 1) == 1)
                         ? 13'h1100 + 13'($urandom_range(0, 16'h06FF))
                         : 13'h1900 + 13'($urandom_range(0, 16'h06FF));
            endcase
            rw = 1'($urandom_range(0, 1));
            st = 2'($urandom_range(0, 2));
            d = 16'($urandom);
            cpu_access(rw, a, d, st[1], st[0], r, lat);
            tests_run++;
            if (rw) begin
                if (r !== model_read(a) || lat !== 4) begin
                    tests_failed++;
                    $display("FAIL rnd_rd %h: got %h lat %0d want %h lat 4",
                             a, r, lat, model_read(a));
                end
            end else begin
                model_write(a, d, st[1], st[0]);
                if (lat !== 3) begin
                    tests_failed++;
                    $display("FAIL rnd_wr %h: lat %0d want 3", a, lat);
                end
            end
        end
    endtask

    task automatic test_random_render;
        logic [15:0] ev [32];
        logic [15:0] es [32];
        logic [15:0] ec [32];
        logic [12:0] a;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (i < 32) begin
                a = pv[$urandom_range(0, 7)];
                TEXTVRAM_ADDR = a[11:0];
                ev[i] = model_read(a);
                a = ps[$urandom_range(0, 7)];
                TEXTSELECT_ADDR = a[7:0];
                es[i] = model_read(a);
                a = pc[$urandom_range(0, 7)];
                TEXTSCROLL_ADDR = a[7:0];
                ec[i] = model_read(a);
            end
            @(negedge clk);
            if (i >= 3) begin
                tests_run++;
                if ({TEXTVRAM_DATA, TEXTSELECT_DATA, TEXTSCROLL_DATA} !==
                    {ev[i-3], es[i-3], ec[i-3]}) begin
                    tests_failed++;
                    $display("FAIL rnd_render%0d: got %h %h %h want %h %h %h",
                             i - 3, TEXTVRAM_DATA, TEXTSELECT_DATA,
                             TEXTSCROLL_DATA, ev[i-3], es[i-3], ec[i-3]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) m_vram[i] = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            m_sel[i] = 16'h0000;
            m_scr[i] = 16'h0000;
        end
        test_reset();
        test_word_write();
        test_byte_writes();
        test_scroll();
        test_unmapped();
        test_collision();
        test_early_drop();
        test_hold_ack();
        test_back_to_back();
        test_reset_mid_ack();
        test_random_cpu();
        test_random_render();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
